// File: rtl/program_store.sv
// Program store feeding the 8-bit CPU: byte-wide load port, registered fetch, holds CPU until a program exists.
// Latency: instruction valid 1 oscillator cycle after instruction_address; cpu_hold registered.
// Backpressure: load_ready drops when the store is full or not in LOAD; excess bytes are dropped and flag overflow.
// Optional: define PROGRAM_STORE_CHECKSUM_EN to build the running byte checksum (otherwise tied to zero).
module program_store #(
    parameter int         DEPTH     = 32,
    parameter logic [7:0] FILL_WORD = 8'hC3
) (
    input  logic                     oscillator,
    input  logic                     reset_n,
    input  logic                     load_mode,
    input  logic                     load_valid,
    input  logic [7:0]               load_data,
    output logic                     load_ready,
    input  logic [7:0]               instruction_address,
    output logic [7:0]               instruction,
    output logic                     cpu_hold,
    output logic [$clog2(DEPTH):0]   program_length,
    output logic                     overflow,
    output logic [7:0]               checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (LW > 8) ? LW : 8;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic [LW-1:0] wr_ptr;
    logic [7:0]    mem [DEPTH];
    logic          xfer;
    logic          enter_load;
    logic          addr_hit;

    assign load_ready     = (state == LOAD) && (wr_ptr < DEPTH_L);
    assign xfer           = load_valid && load_ready;
    assign enter_load     = (state != LOAD) && load_mode;
    assign program_length = wr_ptr;
    // Bounded by program_length (<= DEPTH), so addresses past DEPTH can never alias.
    assign addr_hit       = CW'(instruction_address) < CW'(wr_ptr);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_mode) state_next = LOAD;
            LOAD:    if (!load_mode) state_next = ((wr_ptr != '0) || xfer) ? RUN : IDLE;
            RUN:     if (load_mode) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge oscillator or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            overflow    <= 1'b0;
            instruction <= FILL_WORD;
            cpu_hold    <= 1'b1;
        end else begin
            state       <= state_next;
            // Drops only after a full cycle in RUN; rises on the edge that leaves RUN.
            cpu_hold    <= !((state == RUN) && (state_next == RUN));
            instruction <= ((state == RUN) && addr_hit) ? mem[instruction_address[AW-1:0]] : FILL_WORD;
            if (enter_load) begin
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else if (state == LOAD) begin
                if (xfer)
                    wr_ptr <= wr_ptr + LW'(1);
                else if (load_valid)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge oscillator) begin
        if (xfer)
            mem[wr_ptr[AW-1:0]] <= load_data;
    end

`ifdef PROGRAM_STORE_CHECKSUM_EN
    always_ff @(posedge oscillator or negedge reset_n) begin
        if (!reset_n)
            checksum <= 8'd0;
        else if (enter_load)
            checksum <= 8'd0;
        else if (xfer)
            checksum <= checksum + load_data;
    end
`else
    assign checksum = 8'd0;
`endif

endmodule
